// File: rtl/pkt_hdr_buffer.sv
// Packet header buffer: captures the first BUF_BYTES bytes of a packet,
// holds it for the header parser, and serves 32-bit big-endian reads at
// arbitrary byte offsets until the parser releases the packet.

// One byte lane of the tag-read window: returns the stored byte at
// base+LANE when that offset falls inside the held header, else zero.
module pkt_hdr_lane #(
    parameter int ADDR_WIDTH = 16,
    parameter int BUF_BYTES  = 64,
    parameter int LANE       = 0
) (
    input  logic [ADDR_WIDTH:0]          base,
    input  logic [ADDR_WIDTH:0]          limit,
    input  logic [BUF_BYTES-1:0][7:0]    mem,
    output logic [7:0]                   data
);
    localparam int IW = $clog2(BUF_BYTES);

    logic [ADDR_WIDTH:0] idx;

    // Extra address bit keeps base+3 from wrapping back into the buffer.
    assign idx  = base + (ADDR_WIDTH+1)'(LANE);
    assign data = (idx < limit) ? mem[idx[IW-1:0]] : 8'h00;
endmodule

module pkt_hdr_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 16,
    parameter int BUF_BYTES  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    input  logic                  in_last,
    output logic                  in_ready,
    input  logic [ADDR_WIDTH-1:0] tag_addr_i,
    output logic [DATA_WIDTH-1:0] tag_data_o,
    output logic                  hdr_valid,
    output logic [ADDR_WIDTH-1:0] pkt_len,
    input  logic                  hdr_done
);
    localparam int IW = $clog2(BUF_BYTES);
    localparam int NUM_LANES = 4;

    typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

    state_t                        state, state_nxt;
    logic [ADDR_WIDTH-1:0]         wr_cnt;
    logic [ADDR_WIDTH-1:0]         cnt_inc;
    logic [BUF_BYTES-1:0][7:0]     hdr_mem;
    logic [ADDR_WIDTH:0]           limit;
    logic [NUM_LANES-1:0][7:0]     win;
    logic                          accept;
    logic                          in_window;

    // in_ready is high exactly while in FILL, so it also qualifies the state.
    assign accept    = in_valid & in_ready;
    assign cnt_inc   = (wr_cnt == '1) ? wr_cnt : wr_cnt + 1'b1;
    assign in_window = ({1'b0, wr_cnt} < (ADDR_WIDTH+1)'(BUF_BYTES));
    assign limit     = ({1'b0, pkt_len} < (ADDR_WIDTH+1)'(BUF_BYTES))
                       ? {1'b0, pkt_len} : (ADDR_WIDTH+1)'(BUF_BYTES);

    // Four lanes; lane 0 (byte at the address) lands in the top byte.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        pkt_hdr_lane #(
            .ADDR_WIDTH(ADDR_WIDTH),
            .BUF_BYTES (BUF_BYTES),
            .LANE      (k)
        ) u_lane (
            .base (({1'b0, tag_addr_i})),
            .limit(limit),
            .mem  (hdr_mem),
            .data (win[NUM_LANES-1-k])
        );
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: fill until the last byte, hold until the parser releases.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FILL;
            FILL:    if (accept && in_last) state_nxt = HOLD;
            HOLD:    if (hdr_done) state_nxt = FILL;
            default: state_nxt = IDLE;
        endcase
    end

    // Header storage; bytes past the window are dropped, old contents stay.
    always_ff @(posedge clk) begin
        if (!rst && accept && in_window) hdr_mem[wr_cnt[IW-1:0]] <= in_data;
    end

    // Registered outputs, byte counter and packet length.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_ready   <= 1'b0;
            hdr_valid  <= 1'b0;
            pkt_len    <= '0;
            tag_data_o <= '0;
            wr_cnt     <= '0;
        end else begin
            in_ready   <= (state_nxt == FILL);
            hdr_valid  <= (state_nxt == HOLD);
            // Reads see the packet held at this edge, including the hdr_done edge.
            tag_data_o <= (state == HOLD) ? win : '0;
            case (state)
                IDLE: wr_cnt <= '0;
                FILL: if (accept) begin
                    wr_cnt <= cnt_inc;
                    if (in_last) pkt_len <= cnt_inc;
                end
                HOLD: if (hdr_done) wr_cnt <= '0;
                default: wr_cnt <= '0;
            endcase
        end
    end
endmodule

// File: tb/tb_pkt_hdr_buffer.sv
// Bench for pkt_hdr_buffer: a packet-level model predicts every output each
// cycle, plus directed literal checks from hand-computed values.
module tb_pkt_hdr_buffer;
    localparam int AW = 16;
    localparam int BB = 64;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [AW-1:0] tag_addr = '0;
    logic [DW-1:0] tag_data;
    logic          hdr_valid;
    logic [AW-1:0] pkt_len;
    logic          hdr_done = 1'b0;

    always #5 clk = ~clk;

    pkt_hdr_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUF_BYTES(BB)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_last(in_last), .in_ready(in_ready), .tag_addr_i(tag_addr),
        .tag_data_o(tag_data), .hdr_valid(hdr_valid), .pkt_len(pkt_len),
        .hdr_done(hdr_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- packet-level model ----------------
    bit          chk_en = 1'b0;
    bit          m_boot, m_ready, m_valid;
    int          m_len, m_cnt;
    logic [31:0] m_tag;
    logic [7:0]  cur [BB];
    logic [7:0]  held[BB];

    function automatic logic [31:0] window(input int a);
        logic [31:0] r;
        int lim;
        r = 32'h0;
        lim = (m_len < BB) ? m_len : BB;
        for (int k = 0; k < 4; k++) begin
            int i;
            i = a + k;
            r = {r[23:0], (i < lim) ? held[i] : 8'h00};
        end
        return r;
    endfunction

    task automatic model_step();
        if (rst) begin
            m_boot = 1; m_ready = 0; m_valid = 0; m_len = 0; m_cnt = 0;
            m_tag = 32'h0; chk_en = 1;
        end else begin
            m_tag = m_valid ? window(int'(tag_addr)) : 32'h0;
            if (m_boot) begin
                m_boot = 0; m_ready = 1; m_cnt = 0;
            end else if (m_ready && in_valid) begin
                if (m_cnt < BB) cur[m_cnt] = in_data;
                m_cnt++;
                if (in_last) begin
                    held = cur;
                    m_len = (m_cnt > 65535) ? 65535 : m_cnt;
                    m_ready = 0; m_valid = 1;
                end
            end else if (m_valid && hdr_done) begin
                m_valid = 0; m_ready = 1; m_cnt = 0;
            end
        end
    endtask

    always @(posedge clk) model_step();

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            check("m_ready", 32'(in_ready),  32'(m_ready));
            check("m_valid", 32'(hdr_valid), 32'(m_valid));
            check("m_len",   32'(pkt_len),   32'(m_len));
            check("m_tag",   tag_data,       m_tag);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [7:0] s_data[256];
    bit         s_last[256];

    task automatic stream(input int n);
        for (int i = 0; i < n; i++) begin
            int w;
            w = 0;
            in_valid = 1'b1; in_data = s_data[i]; in_last = s_last[i];
            while (!in_ready && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                tests++; fails++;
                $display("FAIL stream_timeout: byte %0d never accepted", i);
                break;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic read(input logic [AW-1:0] a, input logic [31:0] exp, input string name);
        tag_addr = a;
        @(negedge clk);
        check(name, tag_data, exp);
    endtask

    task automatic pulse_done();
        hdr_done = 1'b1;
        @(negedge clk);
        hdr_done = 1'b0;
    endtask

    task automatic wait_hv(input string name);
        int w;
        w = 0;
        while (!hdr_valid && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!hdr_valid) begin
            tests++; fails++;
            $display("FAIL %s: hdr_valid never rose, got 0 expected 1", name);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(in_ready),  32'h0);
        check("rst_valid", 32'(hdr_valid), 32'h0);
        check("rst_len",   32'(pkt_len),   32'h0);
        check("rst_tag",   tag_data,       32'h0);
        rst = 1'b0;
        check("rel_ready0", 32'(in_ready), 32'h0);
        @(negedge clk);
        check("rel_ready1", 32'(in_ready), 32'h1);

        // Basic hold: 34-byte Ethernet+IPv4 header, ethertype 0800 at 12
        for (int i = 0; i < 34; i++) begin
            s_data[i] = 8'(i * 3 + 1); s_last[i] = (i == 33);
        end
        s_data[12] = 8'h08; s_data[13] = 8'h00;
        stream(34);
        check("t1_valid", 32'(hdr_valid), 32'h1);
        check("t1_len",   32'(pkt_len),   32'd34);
        tag_addr = 16'd12;
        @(negedge clk);
        check("t1_etype", {16'h0, tag_data[31:16]}, 32'h0800);
        // Read on the hdr_done edge still sees the held packet.
        pulse_done();
        check("t1_etype_done", {16'h0, tag_data[31:16]}, 32'h0800);
        check("t1_rel_valid", 32'(hdr_valid), 32'h0);
        check("t1_rel_ready", 32'(in_ready),  32'h1);
        @(negedge clk);
        check("t1_after_rel", tag_data, 32'h0);

        // Tail and truncation: 100 bytes, byte i = i
        for (int i = 0; i < 100; i++) begin
            s_data[i] = 8'(i); s_last[i] = (i == 99);
        end
        stream(100);
        check("t2_len", 32'(pkt_len), 32'd100);
        read(16'd60,    32'h3C3D3E3F, "t2_rd60");
        read(16'd62,    32'h3E3F0000, "t2_rd62");
        read(16'd63,    32'h3F000000, "t2_rd63");
        read(16'd65535, 32'h00000000, "t2_rd65535");
        pulse_done();

        // Short packet over stale buffer contents
        s_data[0] = 8'hAA; s_data[1] = 8'hBB; s_data[2] = 8'hCC;
        s_last[0] = 0; s_last[1] = 0; s_last[2] = 1;
        stream(3);
        check("t3_len", 32'(pkt_len), 32'd3);
        read(16'd0, 32'hAABBCC00, "t3_rd0");
        pulse_done();
        read(16'd0, 32'h0, "t3_rd0_rel");

        // Backpressure: in_valid held across two packets, stray hdr_done in FILL
        for (int i = 0; i < 5; i++) begin
            s_data[i] = 8'h10 + 8'(i); s_last[i] = (i == 4);
        end
        for (int i = 0; i < 6; i++) begin
            s_data[5+i] = 8'h20 + 8'(i); s_last[5+i] = (i == 5);
        end
        fork
            stream(11);
            begin
                wait_hv("t4_hv_a");
                repeat (3) begin
                    check("t4_ready_hold", 32'(in_ready), 32'h0);
                    @(negedge clk);
                end
                check("t4_len_a", 32'(pkt_len), 32'd5);
                read(16'd0, 32'h10111213, "t4_rd_a");
                pulse_done();
                repeat (2) @(negedge clk);
                pulse_done();
                check("t4_stray_valid", 32'(hdr_valid), 32'h0);
                check("t4_stray_ready", 32'(in_ready),  32'h1);
            end
        join
        wait_hv("t4_hv_b");
        check("t4_len_b", 32'(pkt_len), 32'd6);
        read(16'd0, 32'h20212223, "t4_rd_b0");
        read(16'd4, 32'h24250000, "t4_rd_b4");
        pulse_done();

        // Reset mid-packet
        for (int i = 0; i < 10; i++) begin
            s_data[i] = 8'h80 + 8'(i); s_last[i] = 0;
        end
        stream(10);
        rst = 1'b1;
        @(negedge clk);
        check("t5_rst_ready", 32'(in_ready),  32'h0);
        check("t5_rst_valid", 32'(hdr_valid), 32'h0);
        check("t5_rst_len",   32'(pkt_len),   32'h0);
        check("t5_rst_tag",   tag_data,       32'h0);
        rst = 1'b0;
        check("t5_rel_ready0", 32'(in_ready), 32'h0);
        @(negedge clk);
        check("t5_rel_ready1", 32'(in_ready), 32'h1);
        for (int i = 0; i < 20; i++) begin
            s_data[i] = 8'h40 + 8'(i); s_last[i] = (i == 19);
        end
        stream(20);
        check("t5_len", 32'(pkt_len), 32'd20);
        read(16'd0,  32'h40414243, "t5_rd0");
        read(16'd16, 32'h50515253, "t5_rd16");
        read(16'd18, 32'h52530000, "t5_rd18");
        pulse_done();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pkt_hdr_buffer.md
# pkt_hdr_buffer

Packet header buffer that sits directly upstream of the header parser. It accepts an incoming packet as a byte stream and stores the first `BUF_BYTES` bytes. It then holds the packet and serves the parser's random-access tag reads: for a byte address it returns a 32-bit big-endian window. When the parser signals completion, the packet is released and the next one is accepted.

## Interface
- `DATA_WIDTH`, default 32: tag read word width; fixed at 32.
- `ADDR_WIDTH`, default 16: byte-address and length width.
- `BUF_BYTES`, default 64: stored header window, in bytes; power of two, ≥ 4.
- `clk`, input, 1: clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: input byte valid.
- `in_data`, input, 8: packet byte, in wire order.
- `in_last`, input, 1: final byte of the packet; qualified by `in_valid`.
- `in_ready`, output, 1: block accepts a byte this cycle.
- `tag_addr_i`, input, `ADDR_WIDTH`: byte offset for the tag read.
- `tag_data_o`, output, `DATA_WIDTH`: bytes at offsets addr..addr+3, with addr in [31:24].
- `hdr_valid`, output, 1: a complete packet is held and reads are meaningful.
- `pkt_len`, output, `ADDR_WIDTH`: total byte count of the held packet.
- `hdr_done`, input, 1: parser finished; release the held packet.

## Operation
- States: IDLE, FILL, HOLD.
- IDLE: entered on reset. Moves to FILL unconditionally on the next cycle and clears the write counter `wr_cnt`.
- FILL:
  - `in_ready`=1.
  - A byte is accepted when `in_valid & in_ready`.
  - If `wr_cnt` < `BUF_BYTES`, the byte is stored at `buf[wr_cnt]`; otherwise it is dropped (truncation).
  - `wr_cnt` increments on every accepted byte and saturates at 2^`ADDR_WIDTH`−1.
  - An accepted byte with `in_last`=1 makes `pkt_len` = `wr_cnt`+1 (saturating) and moves the block to HOLD.
- HOLD:
  - `in_ready`=0 and `hdr_valid`=1.
  - `hdr_done`=1 moves the block to FILL, clears `wr_cnt`, and drops `hdr_valid`. Buffer contents are not cleared.
  - `hdr_done` in IDLE or FILL is ignored.
- Tag read (all states): `tag_data_o` ← {b(a), b(a+1), b(a+2), b(a+3)} with a = `tag_addr_i`.
  - b(i) = `buf[i]` if i < min(`pkt_len`, `BUF_BYTES`), else 8'h00.
  - Outside HOLD, all reads return 0.
  - Address arithmetic is done at `ADDR_WIDTH`+1 bits, so a+3 does not wrap.
- Packets of length 1 are legal (`in_last` on the first byte).
- Zero-length packets are impossible.

## Timing
- Reset values: state IDLE, `in_ready`=0, `hdr_valid`=0, `pkt_len`=0, `tag_data_o`=0, `wr_cnt`=0.
- `in_ready` first becomes 1 in the second cycle after `rst` deasserts. All outputs are registered.
- The last byte is accepted at edge N. At edge N, `hdr_valid`=1 and `pkt_len` is valid; `in_ready`=0 from edge N.
- Read latency is 1 cycle: `tag_addr_i` sampled at edge N appears on `tag_data_o` after edge N. This matches the parser, which presents a new address each cycle and uses the returned data on the next.
- `hdr_done` sampled at edge M gives `hdr_valid`=0 and `in_ready`=1 after edge M. A new byte can be accepted at edge M+1.
- A read in the same cycle as `hdr_done` still returns the held data. Reads from M+1 onward return 0 until the next HOLD.
- `rst` asserted in any state: takes effect at that edge. Any partial or held packet is discarded and all outputs take their reset values.
- Throughput: one byte per cycle in FILL. Minimum gap between packets is 1 cycle (the `hdr_done` edge).

## Test plan
- **Basic hold:** Send a 34-byte Ethernet+IPv4 packet with bytes 12–13 = 08 00, then read address 12.
  - `hdr_valid`=1 and `pkt_len`=34.
  - `tag_data_o`[31:16]=16'h0800 one cycle after the address is applied.
- **Tail and truncation:** Send a 100-byte packet with byte i = i[7:0].
  - `pkt_len`=100.
  - Read 60 → 32'h3C3D3E3F.
  - Read 62 → 32'h3E3F0000 (bytes ≥ 64 read as 0).
  - Read 65535 → 0.
- **Short packet:** Send 3 bytes AA BB CC.
  - `pkt_len`=3 and read 0 → 32'hAABBCC00.
  - Pulse `hdr_done`, then read 0 → 0.
- **Backpressure:** Assert `in_valid` continuously across two packets.
  - `in_ready`=0 throughout HOLD; no bytes are lost.
  - The second packet's first byte is stored at offset 0 only after `hdr_done`.
  - Stray `hdr_done` during FILL has no effect.
- **Reset mid-packet:** Assert `rst` after 10 bytes of a packet.
  - All outputs are 0.
  - `in_ready`=1 two cycles after release.
  - A following 20-byte packet reports `pkt_len`=20 with correct data.
